// File: rtl/bp_cfg_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bp_cfg_loader_pkg
// Brief    : Shared types for the runtime configuration loader: FSM state
//            encoding, broadcast core-id fill bit and the cfg write record.
// Revision : 1.0 - initial release
// ============================================================================

`ifndef BP_CFG_LOADER_WRITE_S_DEFINED
`define BP_CFG_LOADER_WRITE_S_DEFINED
// One cfg bus write, sized by the instantiating module's width parameters.
`define DECLARE_BP_CFG_WRITE_S(core_w, addr_w, data_w) \
    typedef struct packed {                             \
        logic [core_w-1:0] core;                        \
        logic [addr_w-1:0] addr;                        \
        logic [data_w-1:0] data;                        \
    } bp_cfg_write_s
`endif

package bp_cfg_loader_pkg;

    // Loader sequencing states; 2-bit explicit encoding.
    typedef enum logic [1:0] {
        e_idle  = 2'd0,
        e_send  = 2'd1,
        e_drain = 2'd2,
        e_done  = 2'd3
    } bp_cfg_loader_state_e;

    // The broadcast core id is all ones at whatever core-id width is used;
    // consumers replicate this bit across their core field.
    localparam logic c_bcast_core_bit = 1'b1;

endpackage

`default_nettype wire

// File: rtl/bsg_counter_up_down.sv
`default_nettype none
// ============================================================================
// Module   : bsg_counter_up_down
// Brief    : Saturation-free up/down counter, one step per cycle in each
//            direction. Simultaneous up and down leave the count unchanged.
// Revision : 1.0 - initial release
// ============================================================================

module bsg_counter_up_down #(
    parameter  int max_val_p    = 4,
    parameter  int init_val_p   = 0,
    localparam int ptr_width_lp = $clog2(max_val_p + 1)
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    up_i,
    input  logic                    down_i,
    output logic [ptr_width_lp-1:0] count_o
);

    logic [ptr_width_lp-1:0] r_count;

    // Count moves by +1/-1; the caller guarantees it never leaves [0, max].
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_count <= ptr_width_lp'(init_val_p);
        end else if (up_i && !down_i) begin
            r_count <= r_count + ptr_width_lp'(1);
        end else if (down_i && !up_i) begin
            r_count <= r_count - ptr_width_lp'(1);
        end
    end

    assign count_o = r_count;

endmodule

`default_nettype wire

// File: rtl/bp_cfg_loader.sv
`default_nettype none
// ============================================================================
// Module   : bp_cfg_loader
// Brief    : Walks a table of (addr, data) entries and issues them as cfg
//            writes to every core (core-major order) or once as a broadcast,
//            throttled by a credit count of unacknowledged writes.
// Revision : 1.0 - initial release
// ============================================================================

module bp_cfg_loader
    import bp_cfg_loader_pkg::*;
#(
    parameter int num_core_p       = 4,
    parameter int cfg_core_width_p = 8,
    parameter int cfg_addr_width_p = 16,
    parameter int cfg_data_width_p = 32,
    parameter int max_entries_p    = 8,
    parameter int max_credits_p    = 4
) (
    input  logic                                      clk_i,
    input  logic                                      reset_i,
    input  logic                                      start_i,
    input  logic                                      broadcast_i,
    input  logic [$clog2(max_entries_p+1)-1:0]        num_entries_i,
    input  logic [max_entries_p*cfg_addr_width_p-1:0] entry_addr_i,
    input  logic [max_entries_p*cfg_data_width_p-1:0] entry_data_i,
    output logic                                      cfg_v_o,
    output logic [cfg_core_width_p-1:0]               cfg_core_o,
    output logic [cfg_addr_width_p-1:0]               cfg_addr_o,
    output logic [cfg_data_width_p-1:0]               cfg_data_o,
    input  logic                                      cfg_ready_i,
    input  logic                                      cfg_ack_i,
    output logic                                      busy_o,
    output logic                                      done_o,
    output logic                                      err_o
);

    localparam int c_cnt_w  = $clog2(max_entries_p + 1);
    localparam int c_eidx_w = (max_entries_p > 1) ? $clog2(max_entries_p) : 1;
    localparam int c_cidx_w = (num_core_p > 1) ? $clog2(num_core_p) : 1;
    localparam int c_cred_w = $clog2(max_credits_p + 1);

    `DECLARE_BP_CFG_WRITE_S(cfg_core_width_p, cfg_addr_width_p, cfg_data_width_p);

    bp_cfg_loader_state_e  r_state;
    logic                  r_bcast;
    logic [c_cnt_w-1:0]    r_count;
    logic [c_eidx_w-1:0]   r_entry;
    logic [c_cidx_w-1:0]   r_core;
    logic                  r_err;

    logic [c_cred_w-1:0]   w_credits;
    logic [c_cnt_w-1:0]    w_n;
    logic                  w_valid;
    logic                  w_hs;
    logic                  w_underflow;
    logic                  w_down;
    logic                  w_last_entry;
    logic                  w_last_core;
    bp_cfg_write_s         w_wr;

    logic [cfg_addr_width_p-1:0] w_addr_tab [max_entries_p];
    logic [cfg_data_width_p-1:0] w_data_tab [max_entries_p];

    // Unpack the flat entry buses into per-entry views.
    for (genvar k = 0; k < max_entries_p; k++) begin : g_entry
        assign w_addr_tab[k] = entry_addr_i[k*cfg_addr_width_p +: cfg_addr_width_p];
        assign w_data_tab[k] = entry_data_i[k*cfg_data_width_p +: cfg_data_width_p];
    end

    // Oversized entry counts clamp to the table capacity.
    assign w_n = (num_entries_i > c_cnt_w'(max_entries_p)) ? c_cnt_w'(max_entries_p)
                                                            : num_entries_i;

    assign w_valid      = (r_state == e_send) && (w_credits < c_cred_w'(max_credits_p));
    assign w_hs         = w_valid && cfg_ready_i;
    // An ack with nothing outstanding is an error and must not decrement.
    assign w_underflow  = cfg_ack_i && (w_credits == '0);
    assign w_down       = cfg_ack_i && !w_underflow;
    assign w_last_entry = (c_cnt_w'(r_entry) == (r_count - c_cnt_w'(1)));
    assign w_last_core  = r_bcast || (r_core == c_cidx_w'(num_core_p - 1));

    // Outstanding-write credits: +1 per accepted write, -1 per legal ack.
    bsg_counter_up_down #(
        .max_val_p  (max_credits_p),
        .init_val_p (0)
    ) u_credits (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .up_i    (w_hs),
        .down_i  (w_down),
        .count_o (w_credits)
    );

    // Sequencer: start latching, core-major index walk and drain to done.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state <= e_idle;
            r_bcast <= 1'b0;
            r_count <= '0;
            r_entry <= '0;
            r_core  <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_underflow) begin
                r_err <= 1'b1;
            end
            case (r_state)
                e_idle, e_done: begin
                    if (start_i) begin
                        r_bcast <= broadcast_i;
                        r_count <= w_n;
                        r_entry <= '0;
                        r_core  <= '0;
                        r_err   <= 1'b0;
                        r_state <= (w_n == '0) ? e_drain : e_send;
                    end
                end
                e_send: begin
                    if (w_hs) begin
                        if (w_last_entry && w_last_core) begin
                            r_state <= e_drain;
                        end else if (w_last_entry) begin
                            r_entry <= '0;
                            r_core  <= r_core + c_cidx_w'(1);
                        end else begin
                            r_entry <= r_entry + c_eidx_w'(1);
                        end
                    end
                end
                e_drain: begin
                    // A same-cycle ack defers completion by one cycle.
                    if ((w_credits == '0) && !cfg_ack_i) begin
                        r_state <= e_done;
                    end
                end
                default: begin
                    r_state <= e_idle;
                end
            endcase
        end
    end

    // Payload is driven only while valid so idle outputs read as zero.
    always_comb begin
        w_wr = '0;
        if (w_valid) begin
            w_wr.core = r_bcast ? {cfg_core_width_p{c_bcast_core_bit}}
                                : cfg_core_width_p'(r_core);
            w_wr.addr = w_addr_tab[r_entry];
            w_wr.data = w_data_tab[r_entry];
        end
    end

    assign cfg_v_o    = w_valid;
    assign cfg_core_o = w_wr.core;
    assign cfg_addr_o = w_wr.addr;
    assign cfg_data_o = w_wr.data;
    assign busy_o     = (r_state == e_send) || (r_state == e_drain);
    assign done_o     = (r_state == e_done);
    assign err_o      = r_err;

endmodule

`default_nettype wire

// File: tb/tb_bp_cfg_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_bp_cfg_loader
// Brief    : Self-checking bench for bp_cfg_loader: directed scenarios plus a
//            randomized phase, compared every cycle against a queue model.
// Revision : 1.0 - initial release
// ============================================================================

module tb_bp_cfg_loader;

    localparam int NC = 4;
    localparam int CW = 8;
    localparam int AW = 16;
    localparam int DW = 32;
    localparam int ME = 8;
    localparam int MC = 4;
    localparam int NW = $clog2(ME + 1);

    typedef struct packed {
        logic [CW-1:0] core;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic             bcast = 1'b0;
    logic [NW-1:0]    num = '0;
    logic [ME*AW-1:0] eaddr = '0;
    logic [ME*DW-1:0] edata = '0;
    logic             ready = 1'b0;
    logic             ack = 1'b0;
    logic             cfg_v;
    logic [CW-1:0]    cfg_core;
    logic [AW-1:0]    cfg_addr;
    logic [DW-1:0]    cfg_data;
    logic             busy;
    logic             done;
    logic             err;

    int  checks   = 0;
    int  failures = 0;
    int  cyc      = 0;
    bit  auto_en  = 1'b0;
    bit  rnd_ack  = 1'b0;
    bit  spur_en  = 1'b0;
    bit  man_ack  = 1'b0;
    int  ack_due [$];
    wr_t hs_log  [$];

    // model state
    int  m_phase = 0;   // 0 idle, 1 sending, 2 draining, 3 done
    int  m_out   = 0;
    bit  m_err   = 1'b0;
    wr_t m_q [$];

    bp_cfg_loader #(
        .num_core_p       (NC),
        .cfg_core_width_p (CW),
        .cfg_addr_width_p (AW),
        .cfg_data_width_p (DW),
        .max_entries_p    (ME),
        .max_credits_p    (MC)
    ) dut (
        .clk_i         (clk),
        .reset_i       (rst),
        .start_i       (start),
        .broadcast_i   (bcast),
        .num_entries_i (num),
        .entry_addr_i  (eaddr),
        .entry_data_i  (edata),
        .cfg_v_o       (cfg_v),
        .cfg_core_o    (cfg_core),
        .cfg_addr_o    (cfg_addr),
        .cfg_data_o    (cfg_data),
        .cfg_ready_i   (ready),
        .cfg_ack_i     (ack),
        .busy_o        (busy),
        .done_o        (done),
        .err_o         (err)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures <= 60)
                $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input bit b, input int n);
        bcast = b;
        num   = NW'(n);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int bound);
        int k = 0;
        while (!done && k < bound) begin
            tick();
            k++;
        end
        chk(name, {63'd0, done}, 64'd1);
    endtask

    task automatic wait_ack_idle();
        int k = 0;
        while (ack_due.size() != 0 && k < 50) begin
            tick();
            k++;
        end
    endtask

    task automatic load_directed();
        for (int k = 0; k < ME; k++) begin
            eaddr[k*AW +: AW] = AW'(16'h1000 + k);
            edata[k*DW +: DW] = DW'(32'hA000_0000 + k);
        end
    endtask

    // Ack responder and handshake log (stimulus side; reads DUT only to react).
    initial begin
        bit a_auto;
        bit a_spur;
        forever begin
            @(posedge clk);
            cyc++;
            if (!rst && cfg_v && ready) begin
                hs_log.push_back({cfg_core, cfg_addr, cfg_data});
                if (auto_en)
                    ack_due.push_back(cyc + (rnd_ack ? int'($urandom_range(1, 4)) : 2));
            end
            #2;
            a_auto = 1'b0;
            if (ack_due.size() > 0 && ack_due[0] <= cyc) begin
                void'(ack_due.pop_front());
                a_auto = 1'b1;
            end
            a_spur = spur_en && !a_auto && ($urandom_range(0, 19) == 0);
            ack = a_auto | man_ack | a_spur;
        end
    end

    // Reference model: list of writes still to issue plus an outstanding tally.
    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_phase = 0;
                m_out   = 0;
                m_err   = 1'b0;
                m_q.delete();
            end else begin
                bit v;
                bit hs;
                bit und;
                int old_out;
                int n;
                old_out = m_out;
                v   = (m_phase == 1) && (m_out < MC);
                hs  = v && ready;
                und = ack && (m_out == 0);
                m_out = m_out + (hs ? 1 : 0) - ((ack && !und) ? 1 : 0);
                if (und) m_err = 1'b1;
                case (m_phase)
                    0, 3: begin
                        if (start) begin
                            n = (int'(num) > ME) ? ME : int'(num);
                            m_q.delete();
                            for (int c = 0; c < (bcast ? 1 : NC); c++) begin
                                for (int e = 0; e < n; e++) begin
                                    wr_t w;
                                    w.core = bcast ? 8'hFF : CW'(c);
                                    w.addr = eaddr[e*AW +: AW];
                                    w.data = edata[e*DW +: DW];
                                    m_q.push_back(w);
                                end
                            end
                            m_err   = 1'b0;
                            m_phase = (n == 0) ? 2 : 1;
                        end
                    end
                    1: begin
                        if (hs) begin
                            void'(m_q.pop_front());
                            if (m_q.size() == 0) m_phase = 2;
                        end
                    end
                    default: begin
                        if (old_out == 0 && !ack) m_phase = 3;
                    end
                endcase
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    initial begin
        forever begin
            bit  e_v;
            wr_t e_wr;
            @(negedge clk);
            e_v  = (m_phase == 1) && (m_out < MC) && (m_q.size() > 0);
            e_wr = e_v ? m_q[0] : '0;
            chk("cyc_cfg_v",    {63'd0, cfg_v}, {63'd0, e_v});
            chk("cyc_cfg_core", {56'd0, cfg_core}, {56'd0, e_wr.core});
            chk("cyc_cfg_addr", {48'd0, cfg_addr}, {48'd0, e_wr.addr});
            chk("cyc_cfg_data", {32'd0, cfg_data}, {32'd0, e_wr.data});
            chk("cyc_busy",     {63'd0, busy}, {63'd0, (m_phase == 1 || m_phase == 2)});
            chk("cyc_done",     {63'd0, done}, {63'd0, (m_phase == 3)});
            chk("cyc_err",      {63'd0, err},  {63'd0, m_err});
        end
    end

    // Directed scenarios followed by randomized traffic.
    initial begin
        int base;
        int k;
        rst = 1'b1;
        repeat (3) tick();
        chk("rst_v",    {63'd0, cfg_v}, 64'd0);
        chk("rst_busy", {63'd0, busy},  64'd0);
        chk("rst_done", {63'd0, done},  64'd0);
        chk("rst_err",  {63'd0, err},   64'd0);
        rst = 1'b0;
        tick();

        // unicast, 4 cores x 3 entries, ack two cycles after each write
        load_directed();
        auto_en = 1'b1;
        ready   = 1'b1;
        base    = hs_log.size();
        pulse_start(1'b0, 3);
        chk("first_valid_latency", {63'd0, cfg_v}, 64'd1);
        chk("first_payload", {8'd0, cfg_core, cfg_addr, cfg_data}, {8'd0, 8'h00, 16'h1000, 32'hA000_0000});
        wait_done("uni_done", 200);
        chk("uni_writes", 64'(hs_log.size() - base), 64'd12);
        for (int i = 0; i < 12 && base + i < hs_log.size(); i++)
            chk("uni_order", 64'(hs_log[base+i]),
                64'({CW'(i / 3), AW'(16'h1000 + i % 3), DW'(32'hA000_0000 + i % 3)}));
        if (hs_log.size() >= base + 12)
            chk("uni_last", 64'(hs_log[base+11]), 64'({8'h03, 16'h1002, 32'hA000_0002}));
        chk("uni_err", {63'd0, err}, 64'd0);

        // broadcast, 5 entries
        base = hs_log.size();
        pulse_start(1'b1, 5);
        wait_done("bc_done", 200);
        chk("bc_writes", 64'(hs_log.size() - base), 64'd5);
        for (int i = base; i < hs_log.size(); i++)
            chk("bc_core", {56'd0, hs_log[i].core}, 64'h0FF);

        // credit exhaustion, single-ack release, stall stability
        wait_ack_idle();
        auto_en = 1'b0;
        base = hs_log.size();
        pulse_start(1'b0, 8);
        repeat (8) tick();
        chk("cred_four", 64'(hs_log.size() - base), 64'd4);
        chk("cred_v_low", {63'd0, cfg_v}, 64'd0);
        man_ack = 1'b1; tick(); man_ack = 1'b0;
        repeat (4) tick();
        chk("cred_one_more", 64'(hs_log.size() - base), 64'd5);
        chk("cred_v_low2", {63'd0, cfg_v}, 64'd0);
        ready = 1'b0;
        man_ack = 1'b1; tick(); man_ack = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("stall_v", {63'd0, cfg_v}, 64'd1);
            chk("stall_payload", {8'd0, cfg_core, cfg_addr, cfg_data}, {8'd0, 8'h00, 16'h1005, 32'hA000_0005});
            tick();
        end
        chk("stall_no_write", 64'(hs_log.size() - base), 64'd5);
        ready = 1'b1; tick(); ready = 1'b0;
        repeat (4) begin
            man_ack = 1'b1; tick();
        end
        man_ack = 1'b0;
        tick();
        auto_en = 1'b1;
        ready   = 1'b1;
        wait_done("cred_done", 300);
        chk("cred_total", 64'(hs_log.size() - base), 64'd32);

        // empty table
        wait_ack_idle();
        base = hs_log.size();
        pulse_start(1'b0, 0);
        chk("n0_busy", {63'd0, busy}, 64'd1);
        chk("n0_v",    {63'd0, cfg_v}, 64'd0);
        tick();
        chk("n0_busy_off", {63'd0, busy}, 64'd0);
        chk("n0_done",     {63'd0, done}, 64'd1);
        chk("n0_writes", 64'(hs_log.size() - base), 64'd0);

        // handshake and ack together at two outstanding
        auto_en = 1'b0;
        ready   = 1'b0;
        base    = hs_log.size();
        pulse_start(1'b0, 8);
        ready = 1'b1;
        tick();
        tick();
        man_ack = 1'b1; tick(); man_ack = 1'b0;
        repeat (6) tick();
        chk("simul_writes", 64'(hs_log.size() - base), 64'd5);
        chk("simul_v_low", {63'd0, cfg_v}, 64'd0);
        rst = 1'b1; tick(); rst = 1'b0; tick();

        // spurious ack in idle, cleared by start
        man_ack = 1'b1; tick(); man_ack = 1'b0; tick();
        chk("spur_err", {63'd0, err}, 64'd1);
        auto_en = 1'b1;
        pulse_start(1'b0, 1);
        chk("spur_err_clr", {63'd0, err}, 64'd0);
        wait_done("spur_done", 100);

        // reset mid-sequence
        wait_ack_idle();
        base = hs_log.size();
        pulse_start(1'b0, 3);
        k = 0;
        while (hs_log.size() - base < 6 && k < 50) begin
            tick();
            k++;
        end
        chk("mid_six", 64'(hs_log.size() - base), 64'd6);
        rst = 1'b1;
        #1;
        chk("mid_rst_v",    {63'd0, cfg_v}, 64'd0);
        chk("mid_rst_busy", {63'd0, busy},  64'd0);
        chk("mid_rst_addr", {48'd0, cfg_addr}, 64'd0);
        #1;
        rst = 1'b0;
        repeat (4) tick();
        chk("late_ack_err", {63'd0, err}, 64'd1);
        wait_ack_idle();
        base = hs_log.size();
        pulse_start(1'b0, 3);
        chk("restart_err_clr", {63'd0, err}, 64'd0);
        chk("restart_payload", {8'd0, cfg_core, cfg_addr, cfg_data}, {8'd0, 8'h00, 16'h1000, 32'hA000_0000});
        wait_done("restart_done", 200);
        chk("restart_writes", 64'(hs_log.size() - base), 64'd12);

        // randomized traffic
        wait_ack_idle();
        rnd_ack = 1'b1;
        spur_en = 1'b1;
        for (int it = 0; it < 40; it++) begin
            for (int e = 0; e < ME; e++) begin
                eaddr[e*AW +: AW] = AW'($urandom);
                edata[e*DW +: DW] = DW'($urandom);
            end
            pulse_start(($urandom_range(0, 3) == 0), int'($urandom_range(0, 15)));
            k = 0;
            while (!done && k < 800) begin
                ready = ($urandom_range(0, 3) != 0);
                start = busy && ($urandom_range(0, 15) == 0);
                tick();
                k++;
            end
            start = 1'b0;
            ready = 1'b1;
            chk("rnd_done", {63'd0, done}, 64'd1);
            if (!done) begin
                rst = 1'b1; tick(); rst = 1'b0; tick();
            end
        end
        spur_en = 1'b0;
        repeat (10) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute runtime guard.
    initial begin
        #2000000;
        failures++;
        $display("FAIL global_timeout: got running expected finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire

// File: doc/bp_cfg_loader.md
Name: bp_cfg_loader

Overview:
- Runtime configuration sequencer. Walks a table of (addr, data) config entries and issues them as writes on the cfg bus to every core, or once as a broadcast.
- Throttles issue with a credit counter of outstanding unacknowledged writes.
- Sits between the host/boot controller and the per-core cfg links.
- Replaces compile-time-only core setup with a parametrised, core-count-generic loader.

Parameters:
- num_core_p, 4, number of target cores; must be < 2^cfg_core_width_p.
- cfg_core_width_p, 8, core-id field width.
- cfg_addr_width_p, 16, cfg address width.
- cfg_data_width_p, 32, cfg data width.
- max_entries_p, 8, capacity of the entry table.
- max_credits_p, 4, maximum outstanding unacknowledged writes.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  asynchronous, active-high reset.
- start_i  in  1  start pulse; honoured only in IDLE or DONE.
- broadcast_i  in  1  sampled at start; 1 = one pass with the broadcast core id.
- num_entries_i  in  clog2(max_entries_p+1)  valid entries, sampled at start; values above max_entries_p clamp to max_entries_p.
- entry_addr_i  in  max_entries_p*cfg_addr_width_p  entry addresses; entry k in slice k; must be stable while busy_o.
- entry_data_i  in  max_entries_p*cfg_data_width_p  entry data; same layout and stability rule.
- cfg_v_o  out  1  write valid.
- cfg_core_o  out  cfg_core_width_p  target core id.
- cfg_addr_o  out  cfg_addr_width_p  write address.
- cfg_data_o  out  cfg_data_width_p  write data.
- cfg_ready_i  in  1  write accepted when cfg_v_o & cfg_ready_i.
- cfg_ack_i  in  1  one pulse per completed write.
- busy_o  out  1  high in SEND or DRAIN.
- done_o  out  1  high in DONE.
- err_o  out  1  sticky ack-underflow flag.

Behaviour:
- Reset (async assert, sync release): state IDLE, core/entry indices 0, outstanding 0, mode 0.
  - All outputs 0 during and after reset.
  - Reset mid-operation abandons the sequence immediately; late acks arriving after reset set err_o (counter is 0).
- States: IDLE, SEND, DRAIN, DONE.
  - IDLE/DONE + start_i: latch mode and count, clear indices and err_o.
    - count 0: go to DRAIN.
    - otherwise: go to SEND.
  - SEND -> DRAIN on the handshake of the final write.
  - DRAIN -> DONE when outstanding == 0 and no ack is pending this cycle; an ack that brings outstanding to 0 lets DONE be entered the next cycle.
  - DONE holds until the next start_i.
- Issue order is core-major: core 0 entries 0..n-1, then core 1, and so on up to num_core_p-1.
  - Broadcast mode: one pass, cfg_core_o = all ones.
  - Total writes: n*num_core_p, or n in broadcast mode.
- cfg_v_o = (state==SEND) & (outstanding < max_credits_p).
  - Payload comes from registered indices.
  - Index advances only on handshake, so payload is stable while valid & !ready.
  - Valid never drops before its handshake, because acks only lower outstanding.
- Latency: start in cycle t gives first cfg_v_o in cycle t+1. With ready held high, one write per cycle until credits are exhausted.
- Credit counter, width clog2(max_credits_p+1):
  - +1 on handshake, -1 on ack.
  - Simultaneous handshake and ack: unchanged.
  - Ack with outstanding == 0: counter stays 0 and err_o sets; err_o is cleared only by start_i or reset.
- Index wrap: entry index reaching n-1 wraps to 0 and increments the core index. The final write is core num_core_p-1 (broadcast: core 0 pass), entry n-1.
- start_i during SEND/DRAIN is ignored.

Decomposition:
- Package bp_cfg_loader_pkg holds:
  - enum bp_cfg_loader_state_e {e_idle, e_send, e_drain, e_done};
  - broadcast core-id constant (all ones);
  - cfg write struct macro {core, addr, data} sized by the width parameters.
- Credit tracking uses the existing bsg_counter_up_down; the loader FSM and index logic stay in this module.

Test Plan:
- num_core_p=4, n=3, unicast, ready=1, ack 2 cycles after each handshake -> 12 writes, ordered (0,e0)(0,e1)(0,e2)(1,e0)…(3,e2); done_o rises once outstanding reaches 0; err_o=0.
- Broadcast, n=5 -> exactly 5 writes, all with cfg_core_o=8'hFF; then DONE.
- Acks withheld, max_credits_p=4 -> cfg_v_o drops after 4 handshakes. One ack -> exactly one more write. Payload stays stable across a 3-cycle ready=0 stall.
- n=0 start -> no cfg_v_o; busy_o for 1 cycle; done_o the cycle after.
- Handshake and ack in the same cycle at outstanding=2 -> stays 2. Spurious ack in IDLE -> err_o=1; cleared by the next start_i.
- reset_i asserted mid-SEND after 6 of 12 writes -> outputs 0 immediately. A new start reissues from (0,e0). An old ack arriving after reset sets err_o.
